// File: rtl/mdu_pkg.sv
// Shared definitions for the EXE-stage multiply/divide unit: op encoding,
// FSM state type and the default datapath width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_MULTU = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_DIVU  = 3'b100;
    localparam logic [2:0] MDU_MTHI  = 3'b101;
    localparam logic [2:0] MDU_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath, purely combinational.
// Multiply: acc = {partial_hi, multiplier_remaining}; add the multiplicand
// when the current multiplier bit is set, then shift the whole thing right.
// Divide: acc = {remainder, dividend_remaining}; shift the next dividend bit
// into the remainder and subtract the divisor if it fits (restoring).
// The quotient bit is returned separately and collected by the caller.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_out,
    output logic               q_bit
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;

    // Single shift-add or shift-subtract step selected by is_div.
    always_comb begin
        sum_s    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        rem_sh_s = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
        ge_s     = (rem_sh_s >= {1'b0, operand});
        // Only meaningful when ge_s: the true difference then fits WIDTH bits.
        diff_s   = rem_sh_s[WIDTH-1:0] - operand;
        acc_out  = '0;
        q_bit    = 1'b0;
        if (is_div) begin
            q_bit = ge_s;
            if (ge_s) begin
                acc_out = {diff_s, acc_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = {rem_sh_s[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_in[0]) begin
                acc_out = {sum_s, acc_in[WIDTH-1:1]};
            end else begin
                acc_out = {1'b0, acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/pipe_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Mul/div run on magnitudes one bit per cycle, then a single fix-up cycle
// applies signs and writes HI/LO. MTHI/MTLO write in one edge from IDLE.
module pipe_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(WIDTH - 1);

    // Two's-complement magnitude of v when signed_op and v is negative.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic signed_op);
        if (signed_op && v[WIDTH-1]) begin
            return ~v + ONE_W;
        end else begin
            return v;
        end
    endfunction

    mdu_state_e         state_r, state_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_step_s;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic               is_div_r;
    logic               res_neg_r;
    logic               rem_neg_r;
    logic               div_zero_r;
    logic               q_bit_s;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r;

    logic               is_div_s, is_signed_s, start_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc_in  (acc_r),
        .operand (opnd_r),
        .is_div  (is_div_r),
        .acc_out (acc_step_s),
        .q_bit   (q_bit_s)
    );

    // Op decode, operand magnitudes and sign-corrected results.
    always_comb begin
        is_div_s    = (op == MDU_DIV) || (op == MDU_DIVU);
        is_signed_s = (op == MDU_MULT) || (op == MDU_DIV);
        start_s     = (state_r == IDLE) && op_valid &&
                      ((op == MDU_MULT) || (op == MDU_MULTU) || is_div_s);
        a_mag_s     = abs_val(a, is_signed_s);
        b_mag_s     = abs_val(b, is_signed_s);
        prod_fix_s  = res_neg_r ? (~acc_r + ONE_2W) : acc_r;
        quo_fix_s   = res_neg_r ? (~quo_r + ONE_W) : quo_r;
        rem_fix_s   = rem_neg_r ? (~acc_r[2*WIDTH-1:WIDTH] + ONE_W)
                                : acc_r[2*WIDTH-1:WIDTH];
    end

    // FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (count_r == CNT_END) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register plus busy/done status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= (state_r == FIX);
        end
    end

    // Iteration datapath: operand latch on accept, one step per CALC cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r    <= '0;
            acc_r      <= '0;
            opnd_r     <= '0;
            quo_r      <= '0;
            a_raw_r    <= '0;
            is_div_r   <= 1'b0;
            res_neg_r  <= 1'b0;
            rem_neg_r  <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        count_r    <= '0;
                        acc_r      <= is_div_s ? {ZERO_W, a_mag_s} : {ZERO_W, b_mag_s};
                        opnd_r     <= is_div_s ? b_mag_s : a_mag_s;
                        quo_r      <= '0;
                        a_raw_r    <= a;
                        is_div_r   <= is_div_s;
                        res_neg_r  <= is_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rem_neg_r  <= is_signed_s && a[WIDTH-1];
                        div_zero_r <= is_div_s && (b == ZERO_W);
                    end
                end
                CALC: begin
                    count_r <= count_r + CNT_W'(1);
                    acc_r   <= acc_step_s;
                    quo_r   <= {quo_r[WIDTH-2:0], q_bit_s};
                end
                FIX:     count_r <= '0;
                default: count_r <= '0;
            endcase
        end
    end

    // Architectural HI/LO: MT writes from IDLE, mul/div results in FIX.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (op_valid && (op == MDU_MTHI)) begin
                        hi_r <= a;
                    end
                    if (op_valid && (op == MDU_MTLO)) begin
                        lo_r <= a;
                    end
                end
                FIX: begin
                    if (!is_div_r) begin
                        hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix_s[WIDTH-1:0];
                    end else if (div_zero_r) begin
                        hi_r <= a_raw_r;
                        lo_r <= {WIDTH{1'b1}};
                    end else begin
                        hi_r <= rem_fix_s;
                        lo_r <= quo_fix_s;
                    end
                end
                default: begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            endcase
        end
    end

    assign hi    = hi_r;
    assign lo    = lo_r;
    assign busy  = busy_r;
    assign done  = done_r;
    // Combinational so the upstream registers freeze in the same cycle.
    assign stall = busy_r & (op_valid | rd_hilo);

endmodule
